// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared types, constants and sizing helpers for the gcd_stream block
//
// Purpose : FSM state encoding and iteration-count sizing shared by gcd_stream and gcd_step.
// Contents: gcd_state_t, cnt_width(), iter_bound(), default width and iteration bound.

package gcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } gcd_state_t;

   localparam int GCD_DEF_WIDTH  = 16;
   // Worst-case number of CALC cycles for one job at the default width.
   localparam int GCD_ITER_BOUND = 4*GCD_DEF_WIDTH + 2;

   function automatic int iter_bound(input int width);
      return 4*width + 2;
   endfunction

   // Wide enough to hold iter_bound(width) + 1.
   function automatic int cnt_width(input int width);
      return $clog2(4*width + 3);
   endfunction

endpackage

// File: rtl/gcd_step.sv
// rtl/gcd_step.sv - one combinational binary-GCD (Stein) iteration
//
// Purpose : Given the current a, b and shared power-of-two count k, produce the next values.
// Ports   : i_a, i_b [WIDTH-1:0]  current operands
//           i_k      [KW-1:0]     current count of shared factors of two
//           o_a, o_b, o_k         next values (unchanged when o_eq is set)
//           o_eq                  operands are equal; the job is finished

module gcd_step
   import gcd_pkg::*;
#(
   parameter int WIDTH = GCD_DEF_WIDTH,
   parameter int KW    = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [KW-1:0]    i_k,
   output logic [WIDTH-1:0] o_a,
   output logic [WIDTH-1:0] o_b,
   output logic [KW-1:0]    o_k,
   output logic             o_eq
);

   always_comb begin
      o_a  = i_a;
      o_b  = i_b;
      o_k  = i_k;
      o_eq = 1'b0;
      if (i_a == i_b) begin
         o_eq = 1'b1;
      end else if (!i_a[0] && !i_b[0]) begin
         o_a = i_a >> 1;
         o_b = i_b >> 1;
         o_k = i_k + 1'b1;
      end else if (!i_a[0]) begin
         o_a = i_a >> 1;
      end else if (!i_b[0]) begin
         o_b = i_b >> 1;
      end else if (i_a > i_b) begin
         // Larger operand is always the minuend, so no underflow.
         o_a = i_a - i_b;
      end else begin
         o_b = i_b - i_a;
      end
   end

endmodule

// File: rtl/gcd_stream.sv
// rtl/gcd_stream.sv - handshaked binary-GCD unit with abort and iteration count
//
// Purpose : Accepts one operand pair, iterates gcd_step once per cycle, holds the result.
// Ports   : clk, rst (async active-low), clear (sync abort)
//           in_valid/in_ready, d1, d2       operand side
//           out_valid/out_ready, gcd, cycles result side

module gcd_stream
   import gcd_pkg::*;
#(
   parameter int WIDTH = GCD_DEF_WIDTH,
   parameter int CNT_W = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] gcd,
   output logic [CNT_W-1:0] cycles
);

   localparam int KW = $clog2(WIDTH);

   gcd_state_t       r_state,    w_state_nxt;
   logic [WIDTH-1:0] r_a,        w_a_nxt;
   logic [WIDTH-1:0] r_b,        w_b_nxt;
   logic [KW-1:0]    r_k,        w_k_nxt;
   logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;
   logic [WIDTH-1:0] r_gcd,      w_gcd_nxt;
   logic [CNT_W-1:0] r_cycles,   w_cycles_nxt;
   logic             r_in_ready, w_in_ready_nxt;
   logic             r_out_valid, w_out_valid_nxt;

   logic [WIDTH-1:0] w_step_a;
   logic [WIDTH-1:0] w_step_b;
   logic [KW-1:0]    w_step_k;
   logic             w_step_eq;

   gcd_step #(.WIDTH(WIDTH), .KW(KW)) u_step (
      .i_a  (r_a),
      .i_b  (r_b),
      .i_k  (r_k),
      .o_a  (w_step_a),
      .o_b  (w_step_b),
      .o_k  (w_step_k),
      .o_eq (w_step_eq)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_k         <= '0;
         r_cnt       <= '0;
         r_gcd       <= '0;
         r_cycles    <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_a         <= w_a_nxt;
         r_b         <= w_b_nxt;
         r_k         <= w_k_nxt;
         r_cnt       <= w_cnt_nxt;
         r_gcd       <= w_gcd_nxt;
         r_cycles    <= w_cycles_nxt;
         r_in_ready  <= w_in_ready_nxt;
         r_out_valid <= w_out_valid_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_a_nxt         = r_a;
      w_b_nxt         = r_b;
      w_k_nxt         = r_k;
      w_cnt_nxt       = r_cnt;
      w_gcd_nxt       = r_gcd;
      w_cycles_nxt    = r_cycles;
      w_in_ready_nxt  = r_in_ready;
      w_out_valid_nxt = r_out_valid;

      if (clear) begin
         // Abort wins over acceptance and the result handshake; gcd/cycles keep the last result.
         w_state_nxt     = IDLE;
         w_out_valid_nxt = 1'b0;
         w_in_ready_nxt  = 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               // in_ready rises on the first edge in IDLE (e.g. just after reset).
               w_in_ready_nxt = 1'b1;
               if (in_valid && r_in_ready) begin
                  w_a_nxt        = d1;
                  w_b_nxt        = d2;
                  w_k_nxt        = '0;
                  w_cnt_nxt      = '0;
                  w_in_ready_nxt = 1'b0;
                  if (d1 == '0 || d2 == '0) begin
                     w_gcd_nxt       = d1 | d2;
                     w_cycles_nxt    = '0;
                     w_out_valid_nxt = 1'b1;
                     w_state_nxt     = DONE;
                  end else begin
                     w_state_nxt = CALC;
                  end
               end
            end
            CALC: begin
               w_cnt_nxt = r_cnt + 1'b1;
               if (w_step_eq) begin
                  w_gcd_nxt       = r_a << r_k;
                  w_cycles_nxt    = r_cnt + 1'b1;
                  w_out_valid_nxt = 1'b1;
                  w_state_nxt     = DONE;
               end else begin
                  w_a_nxt = w_step_a;
                  w_b_nxt = w_step_b;
                  w_k_nxt = w_step_k;
               end
            end
            DONE: begin
               if (out_ready) begin
                  w_out_valid_nxt = 1'b0;
                  w_in_ready_nxt  = 1'b1;
                  w_state_nxt     = IDLE;
               end
            end
            default: begin
               w_state_nxt     = IDLE;
               w_out_valid_nxt = 1'b0;
               w_in_ready_nxt  = 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign gcd       = r_gcd;
   assign cycles    = r_cycles;

endmodule

// File: tb/tb_gcd_stream.sv
// tb/tb_gcd_stream.sv - scoreboard bench for gcd_stream (WIDTH=16 directed, WIDTH=8 model-checked)

module tb_gcd_stream;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] d1;
   logic [15:0] d2;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] gcd;
   logic [6:0]  cycles;

   logic        clear8;
   logic        in_valid8;
   logic        in_ready8;
   logic [7:0]  d1_8;
   logic [7:0]  d2_8;
   logic        out_valid8;
   logic        out_ready8;
   logic [7:0]  gcd8;
   logic [5:0]  cycles8;

   always #5 clk = ~clk;

   gcd_stream #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .d1(d1), .d2(d2),
      .out_valid(out_valid), .out_ready(out_ready), .gcd(gcd), .cycles(cycles)
   );

   gcd_stream #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .clear(clear8),
      .in_valid(in_valid8), .in_ready(in_ready8), .d1(d1_8), .d2(d2_8),
      .out_valid(out_valid8), .out_ready(out_ready8), .gcd(gcd8), .cycles(cycles8)
   );

   typedef struct {
      int g;
      int cyc;
      int lat;
   } exp_t;

   exp_t q[$];
   int   n_pass  = 0;
   int   n_total = 0;
   bit   armed   = 1'b0;
   int   lat_cnt = 0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic check_le(input string name, input int act, input int lim);
      n_total++;
      if (act <= lim) n_pass++;
      else $display("FAIL %s: got %0d expected <= %0d", name, act, lim);
   endtask

   task automatic fail_now(input string name);
      n_total++;
      $display("FAIL %s: got timeout expected event", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one pair; push the expected result when a result is expected.
   task automatic send(input int a, input int b, input bit push, input int g, input int cyc, input int lat);
      exp_t e;
      int n = 0;
      while (!in_ready && n < 300) begin tick(); n++; end
      if (!in_ready) fail_now("in_ready_wait");
      d1 = 16'(a);
      d2 = 16'(b);
      in_valid = 1'b1;
      if (push) begin
         e.g = g; e.cyc = cyc; e.lat = lat;
         q.push_back(e);
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() > 0 && n < 500) begin tick(); n++; end
      if (q.size() > 0) fail_now("drain");
   endtask

   function automatic int euclid(input int a, input int b);
      int t;
      while (b != 0) begin t = a % b; a = b; b = t; end
      return a;
   endfunction

   // Monitor: latency measured from the acceptance edge (counted as 1) to the edge raising out_valid.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         armed = 1'b0;
      end else begin
         if (clear) begin
            armed = 1'b0;
         end else if (armed) begin
            if (out_valid) begin
               if (q.size() > 0 && q[0].lat >= 0) check("latency", lat_cnt, q[0].lat);
               armed = 1'b0;
            end else begin
               lat_cnt++;
            end
         end
         if (in_valid && in_ready && !clear) begin
            armed   = 1'b1;
            lat_cnt = 1;
         end
         if (out_valid && out_ready && !clear) begin
            if (q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_result: got gcd %0d expected none", gcd);
            end else begin
               e = q.pop_front();
               check("gcd", int'(gcd), e.g);
               if (e.cyc >= 0) check("cycles", int'(cycles), e.cyc);
               else check_le("cycles_bound", int'(cycles), 66);
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int a8, b8, g8;
      rst = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; d1 = '0; d2 = '0;
      clear8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b1; d1_8 = '0; d2_8 = '0;

      #100;
      check("rst_in_ready", int'(in_ready), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_gcd", int'(gcd), 0);
      check("rst_cycles", int'(cycles), 0);
      tick();
      rst = 1'b1;
      check("pre_edge_in_ready", int'(in_ready), 0);
      tick();
      check("post_edge_in_ready", int'(in_ready), 1);

      // Main function, back-to-back with out_ready held high.
      send(12, 18, 1, 6, 5, 6);
      send(78, 114, 1, 6, 10, 11);
      send(77, 35, 1, 7, 7, 8);
      drain();

      // Zero and boundary cases.
      send(0, 0, 1, 0, 0, 1);
      send(0, 40, 1, 40, 0, 1);
      send(65535, 1, 1, 1, 31, 32);
      send(32768, 32768, 1, 32768, 1, 2);
      send(65535, 65534, 1, 1, 46, 47);
      drain();

      // Backpressure: result must hold while inputs churn.
      out_ready = 1'b0;
      send(200, 150, 1, 50, 6, 7);
      n = 0;
      while (!out_valid && n < 100) begin tick(); n++; end
      if (!out_valid) fail_now("bp_out_valid_wait");
      for (int i = 0; i < 10; i++) begin
         d1 = 16'($urandom);
         d2 = 16'($urandom);
         in_valid = i[0];
         tick();
         check("bp_gcd", int'(gcd), 50);
         check("bp_cycles", int'(cycles), 6);
         check("bp_in_ready", int'(in_ready), 0);
         check("bp_out_valid", int'(out_valid), 1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bp_handshake_out_valid", int'(out_valid), 0);
      check("bp_handshake_in_ready", int'(in_ready), 1);
      check("bp_queue_empty", q.size(), 0);

      // Abort mid-CALC, then a normal job.
      send(65535, 1, 0, 0, 0, 0);
      repeat (5) tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clr_in_ready", int'(in_ready), 1);
      check("clr_out_valid", int'(out_valid), 0);
      check("clr_gcd_kept", int'(gcd), 50);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) n++;
         tick();
      end
      check("clr_no_result", n, 0);
      send(9, 6, 1, 3, 4, 5);
      drain();

      // Asynchronous reset mid-CALC.
      send(65535, 1, 0, 0, 0, 0);
      repeat (5) tick();
      rst = 1'b0;
      #1;
      check("arst_in_ready", int'(in_ready), 0);
      check("arst_out_valid", int'(out_valid), 0);
      check("arst_gcd", int'(gcd), 0);
      check("arst_cycles", int'(cycles), 0);
      tick();
      rst = 1'b1;
      tick();
      check("arst_release_in_ready", int'(in_ready), 1);
      send(0, 7, 1, 7, 0, 1);
      drain();

      // WIDTH=8 instance against a Euclid reference.
      for (int i = 0; i < 500; i++) begin
         a8 = $urandom_range(0, 255);
         b8 = $urandom_range(0, 255);
         g8 = euclid(a8, b8);
         n = 0;
         while (!in_ready8 && n < 50) begin tick(); n++; end
         if (!in_ready8) fail_now("w8_in_ready_wait");
         d1_8 = 8'(a8);
         d2_8 = 8'(b8);
         in_valid8 = 1'b1;
         tick();
         in_valid8 = 1'b0;
         n = 0;
         while (!out_valid8 && n < 40) begin tick(); n++; end
         if (!out_valid8) fail_now("w8_out_valid_wait");
         else begin
            check("w8_gcd", int'(gcd8), g8);
            check_le("w8_cycles_bound", int'(cycles8), 34);
         end
      end

      tick();
      check("final_queue_empty", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/gcd_stream.md
Name: gcd_stream

Overview:
- Parametrised successor to the lab GCD unit; computes gcd(A,B) of two unsigned WIDTH-bit operands using the binary (Stein) algorithm: shifts and subtracts only, no divider.
- Adds a valid/ready handshake on both the operand and result sides, a synchronous abort, and a per-job iteration count.
- Sits between an operand source (switch/UART front end) and a result consumer (display driver), one job in flight at a time.

Parameters:
- WIDTH, 16, operand and result width in bits (>=2).
- CNT_W, $clog2(4*WIDTH+3), width of the iteration counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous abort; returns the block to IDLE and drops any job.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts an operand pair.
- d1  in  WIDTH  operand A.
- d2  in  WIDTH  operand B.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- gcd  out  WIDTH  result.
- cycles  out  CNT_W  number of CALC cycles the job used.

Behaviour:
- Reset while rst=0: state=IDLE, in_ready=0, out_valid=0, gcd=0, cycles=0, internal a/b/k cleared. Reset takes effect immediately, including in the middle of a job.
- First clk edge after rst deasserts: in_ready is set to 1. in_ready is registered and equals 1 only in IDLE.
- States are IDLE, CALC and DONE.
- IDLE:
  - An operand pair is accepted on an edge with in_valid=1 and in_ready=1.
  - On acceptance: a<=d1, b<=d2, k<=0, cnt<=0, in_ready<=0.
  - If d1==0 or d2==0: gcd<=d1|d2, cycles<=0, go to DONE. This covers gcd(0,0)=0.
  - Otherwise go to CALC.
- CALC: exactly one step per cycle and cnt increments every cycle. Steps are evaluated in priority order:
  1. a==b: gcd<=a<<k, cycles<=cnt+1, go to DONE.
  2. a and b both even: a>>=1, b>>=1, k++.
  3. a even: a>>=1.
  4. b even: b>>=1.
  5. Both odd and a>b: a<=a-b.
  6. Otherwise: b<=b-a.
- CALC arithmetic rules:
  - Subtraction is WIDTH-bit and never underflows, because the larger operand is always the minuend.
  - k is at most WIDTH-1 and the shifted result fits in WIDTH bits.
  - Every job terminates within 4*WIDTH+2 CALC cycles.
- DONE:
  - out_valid=1; gcd and cycles are held stable.
  - On an edge with out_ready=1: out_valid<=0, in_ready<=1, go to IDLE.
  - Back-to-back operation: a new pair can be accepted on the edge after the result handshake.
- Input rules:
  - d1/d2 are sampled only on acceptance; changes during CALC/DONE are ignored.
  - in_valid during CALC/DONE is not accepted and is not queued.
- clear:
  - clear=1 on an edge goes to IDLE from any state: out_valid<=0, in_ready<=1, gcd and cycles keep their old values.
  - clear has priority over acceptance and over the result handshake on the same edge.
- Latency: the first CALC cycle is the edge after acceptance. out_valid rises the cycle after the final CALC step, so total latency is cycles+1 clocks from acceptance.

Decomposition:
- gcd_pkg holds:
  - state enum {IDLE, CALC, DONE}.
  - function cnt_width(WIDTH) returning $clog2(4*WIDTH+3).
  - a localparam for the iteration bound 4*WIDTH+2.
- Sub-module gcd_step: purely combinational, one Stein iteration. It takes a, b, k and returns next a, b, k plus an eq flag, parametrised by WIDTH. The top level contains the FSM, the handshake and the registers.

Test Plan:
- Reset then idle: rst low 100 ns -> all outputs 0; in_ready=1 one edge after release.
- d1=12, d2=18 -> gcd=6, cycles=5, out_valid rises 6 clocks after acceptance. Then d1=78, d2=114 -> gcd=6. Then d1=77, d2=35 -> gcd=7, accepted back-to-back with out_ready tied high.
- Zero and boundary cases:
  - (0,0) -> gcd=0, cycles=0, out_valid 1 clock after acceptance.
  - (0,40) -> 40.
  - (65535,1) -> 1.
  - (32768,32768) -> 32768.
  - (65535,65534) -> 1 with cycles<=66.
- Backpressure: out_ready held 0 for 10 clocks with d1/d2/in_valid toggling -> gcd/cycles stable, no new acceptance, in_ready=0. out_ready=1 -> single handshake, in_ready=1 next edge.
- Aborts:
  - clear pulsed mid-CALC on (65535,1) -> IDLE next edge, out_valid never rises; a following (9,6) -> gcd=3.
  - rst pulsed mid-CALC -> outputs immediately 0.
- WIDTH=8 instance: randomised 500 pairs checked against a Euclid reference model; cycles<=34 on every job.
